// File: rtl/byte_packer_pkg.sv
// Shared constants, the clog2 helper and the FIFO entry layout for the byte packer.
package byte_packer_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEF_MST_DWIDTH = 32;
  localparam int DEF_SYS_DWIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int BYTES = DEF_MST_DWIDTH / DEF_SYS_DWIDTH;
  localparam int CNT_W = clog2(BYTES) + 1;

  // Entry layout as stored in the FIFO: byte count above the data word.
  typedef struct packed {
    logic [CNT_W-1:0]          bytes;
    logic [DEF_MST_DWIDTH-1:0] word;
  } entry_t;

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out handshake bundle of the byte packer.
interface byte_packer_if
  import byte_packer_pkg::*;
#(
  parameter int MST_DWIDTH = DEF_MST_DWIDTH,
  parameter int SYS_DWIDTH = DEF_SYS_DWIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int BW = clog2(MST_DWIDTH / SYS_DWIDTH) + 1;
  localparam int FW = clog2(FIFO_DEPTH) + 1;

  logic [SYS_DWIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  flush_i;
  logic [MST_DWIDTH-1:0] data_o;
  logic [BW-1:0]         bytes_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [FW-1:0]         fill_o;
  logic                  overflow_o;
  logic                  clear_ovf_i;

  modport slave (
    input  data_i, valid_i, flush_i, ready_i, clear_ovf_i,
    output data_o, bytes_o, valid_o, fill_o, overflow_o
  );

  modport master (
    output data_i, valid_i, flush_i, ready_i, clear_ovf_i,
    input  data_o, bytes_o, valid_o, fill_o, overflow_o
  );
endinterface

// File: rtl/byte_packer_word_fifo.sv
// Show-ahead FIFO: the head entry is visible on pop_data while not empty (zero when empty).
module word_fifo
  import byte_packer_pkg::*;
#(
  parameter int WIDTH = 35,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [clog2(DEPTH):0] fill
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign fill  = count;

  // A push while full only lands if the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/byte_packer.sv
// Repacks an MSB-first byte stream into words, queued in a show-ahead FIFO with overflow tracking.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int MST_DWIDTH = DEF_MST_DWIDTH,
  parameter int SYS_DWIDTH = DEF_SYS_DWIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk_sys,
  input  logic         rst,
  byte_packer_if.slave bus
);
  localparam int NB = MST_DWIDTH / SYS_DWIDTH;
  localparam int CW = clog2(NB) + 1;
  localparam int FW = clog2(FIFO_DEPTH) + 1;
  localparam int EW = CW + MST_DWIDTH;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         pending;
  logic [MST_DWIDTH-1:0] partial;
  logic [MST_DWIDTH-1:0] merged;
  logic                  full_push;
  logic                  flush_push;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [EW-1:0]         head;
  logic [FW-1:0]         fill;

  assign pending = cnt + CW'(bus.valid_i);

  // Byte k of a word fills the k-th slot from the top, so the first byte ends up as the MSB.
  always_comb begin
    merged = partial;
    if (bus.valid_i) begin
      for (int k = 0; k < NB; k++) begin
        if (cnt == CW'(k)) merged[(NB-1-k)*SYS_DWIDTH +: SYS_DWIDTH] = bus.data_i;
      end
    end
  end

  assign full_push  = bus.valid_i && (pending == CW'(NB));
  assign flush_push = bus.flush_i && !full_push && (pending != '0);
  assign push       = full_push || flush_push;
  assign pop        = !empty && bus.ready_i;
  assign drop       = push && full && !pop;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      partial <= '0;
    end else if (push) begin
      cnt     <= '0;
      partial <= '0;
    end else if (bus.valid_i) begin
      cnt     <= pending;
      partial <= merged;
    end
  end

  // A new drop outranks a clear requested on the same edge.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                  overflow <= 1'b0;
    else if (drop)            overflow <= 1'b1;
    else if (bus.clear_ovf_i) overflow <= 1'b0;
  end

  word_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .push      (push),
    .push_data ({pending, merged}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  assign bus.data_o     = head[MST_DWIDTH-1:0];
  assign bus.bytes_o    = head[EW-1 -: CW];
  assign bus.valid_o    = !empty;
  assign bus.fill_o     = fill;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus random traffic against a queue model.
module tb_byte_packer;
  import byte_packer_pkg::*;

  localparam int NB    = BYTES;
  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic clk_sys = 1'b0;
  logic rst     = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic [7:0] pend[$];
  entry_t     mq[$];
  logic       ovf_m;

  always #5 clk_sys = ~clk_sys;

  byte_packer_if bus ();

  byte_packer dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  function automatic entry_t make_entry();
    entry_t e;
    e.word  = '0;
    e.bytes = CNT_W'(pend.size());
    for (int k = 0; k < pend.size(); k++) e.word = e.word | (32'(pend[k]) << ((NB-1-k)*8));
    return e;
  endfunction

  task automatic model_reset();
    pend.delete();
    mq.delete();
    ovf_m = 1'b0;
  endtask

  // One clock edge with the inputs currently driven; the model follows the stated rules.
  task automatic step();
    logic v, f, r, c, have, do_pop, was_full;
    logic [7:0] d;
    entry_t e, gone;
    v = bus.valid_i; f = bus.flush_i; r = bus.ready_i; c = bus.clear_ovf_i; d = bus.data_i;
    @(posedge clk_sys);
    do_pop   = (mq.size() != 0) && r;
    was_full = (mq.size() == DEPTH);
    have     = 1'b0;
    if (v) pend.push_back(d);
    if (pend.size() == NB || (f && pend.size() != 0)) begin
      e = make_entry();
      pend.delete();
      have = 1'b1;
    end
    if (do_pop) gone = mq.pop_front();
    if (have && was_full && !do_pop) ovf_m = 1'b1;
    else begin
      if (have) mq.push_back(e);
      if (c) ovf_m = 1'b0;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.valid_i = 1'b1;
    bus.data_i  = b;
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    bus.valid_i = 0; bus.data_i = 0; bus.flush_i = 0; bus.ready_i = 0; bus.clear_ovf_i = 0;
    #1 rst = 1'b1;
    #11;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", bus.valid_o); end
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", bus.data_o); end
    checks++; if (bus.bytes_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_bytes: got %0d want 0", bus.bytes_o); end
    checks++; if (bus.fill_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_fill: got %0d want 0", bus.fill_o); end
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b want 0", bus.overflow_o); end
    @(negedge clk_sys);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pack();
    bus.ready_i = 1'b1;
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL pack_valid: got %0b want 1", bus.valid_o); end
    checks++; if (bus.data_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL pack_data: got %h want DEADBEEF", bus.data_o); end
    checks++; if (bus.bytes_o !== 3'd4) begin errors++; $display("[TB] FAIL pack_bytes: got %0d want 4", bus.bytes_o); end
    step();
    checks++; if (bus.fill_o !== 3'd0) begin errors++; $display("[TB] FAIL pack_fill_after_pop: got %0d want 0", bus.fill_o); end
  endtask

  task automatic test_gaps();
    logic [7:0] seq [4];
    seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bus.ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(seq[k]);
      if (k < 3) begin
        idle(int'($urandom_range(1, 3)));
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL gaps_early_valid: got %0b want 0 at byte %0d", bus.valid_o, k); end
      end
    end
    checks++; if (bus.data_o !== 32'hDEADBEEF || bus.valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL gaps_word: got %h/%0b want DEADBEEF/1", bus.data_o, bus.valid_o);
    end
    idle(1);
  endtask

  task automatic test_flush();
    bus.ready_i = 1'b1;
    send(8'h12); send(8'h34);
    bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
    checks++; if (bus.data_o !== 32'h12340000) begin errors++; $display("[TB] FAIL flush_data: got %h want 12340000", bus.data_o); end
    checks++; if (bus.bytes_o !== 3'd2) begin errors++; $display("[TB] FAIL flush_bytes: got %0d want 2", bus.bytes_o); end
    step();
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    checks++; if (bus.data_o !== 32'h55667788 || bus.bytes_o !== 3'd4) begin
      errors++; $display("[TB] FAIL flush_next_word: got %h/%0d want 55667788/4", bus.data_o, bus.bytes_o);
    end
    step();
    bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0 || bus.fill_o !== 3'd0) begin
      errors++; $display("[TB] FAIL flush_empty: got valid %0b fill %0d want 0/0", bus.valid_o, bus.fill_o);
    end
    send(8'h01); send(8'h02); send(8'h03);
    bus.flush_i = 1'b1; send(8'h04); bus.flush_i = 1'b0;
    checks++; if (bus.data_o !== 32'h01020304 || bus.bytes_o !== 3'd4) begin
      errors++; $display("[TB] FAIL flush_with_last: got %h/%0d want 01020304/4", bus.data_o, bus.bytes_o);
    end
    step();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_extra: got valid %0b want 0", bus.valid_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    bus.ready_i = 1'b0;
    for (int i = 1; i <= 20; i++) send(8'(i));
    checks++; if (bus.fill_o !== 3'd4) begin errors++; $display("[TB] FAIL ovf_fill: got %0d want 4", bus.fill_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b want 1", bus.overflow_o); end
    send(8'hA0); send(8'hA1); send(8'hA2);
    bus.clear_ovf_i = 1'b1; send(8'hA3); bus.clear_ovf_i = 1'b0;
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_beats_clear: got %0b want 1", bus.overflow_o); end
    bus.ready_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      want = ((32'(4*w+1)) << 24) | ((32'(4*w+2)) << 16) | ((32'(4*w+3)) << 8) | 32'(4*w+4);
      checks++; if (bus.data_o !== want) begin errors++; $display("[TB] FAIL ovf_drain_order: got %h want %h", bus.data_o, want); end
      step();
    end
    checks++; if (bus.overflow_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_after_drain: got ovf %0b valid %0b want 1/0", bus.overflow_o, bus.valid_o);
    end
    bus.clear_ovf_i = 1'b1; step(); bus.clear_ovf_i = 1'b0;
    checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %0b want 0", bus.overflow_o); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0]  b;
    logic [31:0] new_word;
    bus.ready_i = 1'b0;
    repeat (16) send(8'($urandom));
    new_word = '0;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      new_word = (new_word << 8) | 32'(b);
      if (k == 3) bus.ready_i = 1'b1;
      send(b);
    end
    bus.ready_i = 1'b0;
    checks++; if (bus.overflow_o !== 1'b0 || bus.fill_o !== 3'd4) begin
      errors++; $display("[TB] FAIL fullpp_state: got ovf %0b fill %0d want 0/4", bus.overflow_o, bus.fill_o);
    end
    checks++; if (bus.data_o !== mq[0].word) begin errors++; $display("[TB] FAIL fullpp_head: got %h want %h", bus.data_o, mq[0].word); end
    bus.ready_i = 1'b1;
    idle(3);
    checks++; if (bus.data_o !== new_word) begin errors++; $display("[TB] FAIL fullpp_last: got %h want %h", bus.data_o, new_word); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    repeat (6) send(8'($urandom));
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.valid_o !== 1'b0 || bus.fill_o !== 3'd0 || bus.data_o !== 32'h0) begin
      errors++; $display("[TB] FAIL rstmid_async: got valid %0b fill %0d data %h want 0/0/0", bus.valid_o, bus.fill_o, bus.data_o);
    end
    model_reset();
    @(negedge clk_sys);
    rst = 1'b0;
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    checks++; if (bus.data_o !== 32'hA1B2C3D4 || bus.bytes_o !== 3'd4 || bus.fill_o !== 3'd1) begin
      errors++; $display("[TB] FAIL rstmid_word: got %h/%0d fill %0d want A1B2C3D4/4 fill 1", bus.data_o, bus.bytes_o, bus.fill_o);
    end
    bus.ready_i = 1'b1;
    idle(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.valid_i     = ($urandom_range(0, 9) < 7);
      bus.data_i      = 8'($urandom);
      bus.flush_i     = ($urandom_range(0, 9) == 0);
      bus.ready_i     = ($urandom_range(0, 9) < 4);
      bus.clear_ovf_i = ($urandom_range(0, 19) == 0);
      step();
      checks++; if (bus.valid_o !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rand_valid: got %0b want %0b", bus.valid_o, mq.size() != 0); end
      checks++; if (bus.fill_o !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rand_fill: got %0d want %0d", bus.fill_o, mq.size()); end
      checks++; if (bus.overflow_o !== ovf_m) begin errors++; $display("[TB] FAIL rand_ovf: got %0b want %0b", bus.overflow_o, ovf_m); end
      if (mq.size() != 0) begin
        checks++; if (bus.data_o !== mq[0].word || bus.bytes_o !== mq[0].bytes) begin
          errors++; $display("[TB] FAIL rand_head: got %h/%0d want %h/%0d", bus.data_o, bus.bytes_o, mq[0].word, mq[0].bytes);
        end
      end
    end
    bus.valid_i = 0; bus.flush_i = 0; bus.clear_ovf_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pack();
    test_gaps();
    test_flush();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Downstream stage on one output channel of the master-to-system demux. It consumes that channel's MSB-first byte stream (data/valid, no backpressure) and repacks it into MST_DWIDTH words.
- It buffers the words in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the consumer.
- It flags words lost to overflow and supports flushing a partial word.

Parameters:
- MST_DWIDTH, 32: output word width. Must be an integer multiple of SYS_DWIDTH.
- SYS_DWIDTH, 8: input byte width.
- FIFO_DEPTH, 4: number of words the FIFO can hold. Must be a power of 2 and at least 2.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- data_i  in  SYS_DWIDTH  input byte.
- valid_i  in  1  byte strobe; one byte is taken per cycle while high.
- flush_i  in  1  single-cycle pulse; emits the pending partial word.
- data_o  out  MST_DWIDTH  word at the FIFO head.
- bytes_o  out  CNT_W  number of meaningful bytes in data_o, range 1..BYTES.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o.
- fill_o  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky flag; set when a word was dropped.
- clear_ovf_i  in  1  clears overflow_o.

Behaviour:
- Derived constants: BYTES = MST_DWIDTH/SYS_DWIDTH; CNT_W = clog2(BYTES)+1.
- Reset (async assert while rst=1; release is synchronised to clk_sys by the system, not inside this block):
  - data_o=0, bytes_o=0, valid_o=0, fill_o=0, overflow_o=0.
  - Byte counter=0 and the partial word is cleared.
  - Reset asserted mid-word or with words stored discards everything; no word is emitted on exit from reset.
- Packing:
  - The k-th accepted byte of a word (k=0..BYTES-1) lands in bits [(BYTES-1-k)*SYS_DWIDTH +: SYS_DWIDTH], so the first byte is the MSB. This is the inverse of the demux serialisation.
  - The byte counter increments once per valid_i cycle.
  - On the cycle that accepts byte BYTES-1, the completed word (bytes=BYTES) is pushed into the FIFO at that edge and the counter returns to 0.
- Latency: last byte sampled at edge N → valid_o=1 and data_o=word after edge N. The FIFO is show-ahead; there is no extra read cycle.
- Flush:
  - If flush_i=1 and the pending byte count (including a byte accepted in the same cycle) is between 1 and BYTES-1, push the partial word with unused low bytes zero, bytes=count. Counter returns to 0.
  - flush_i with count 0 is ignored.
  - flush_i in the same cycle as the byte that completes a word: only the normal full word is pushed, with no extra empty word.
- FIFO handshake:
  - Pop occurs on any cycle with valid_o && ready_i. ready_i is ignored when empty.
  - When valid_o=1 and ready_i=0, data_o and bytes_o must hold stable.
  - Words leave in push order.
  - Pointers wrap modulo FIFO_DEPTH.
- Full conditions:
  - Push while full with no pop in the same cycle: the word is dropped, FIFO contents are unchanged, and overflow_o is set from the next cycle.
  - Push and pop in the same cycle while full: both take effect, no overflow, fill_o unchanged.
  - Push and pop in the same cycle while holding 1 word: valid_o stays 1 and data_o advances to the new word.
- Overflow:
  - overflow_o stays set until clear_ovf_i is sampled high.
  - clear_ovf_i and a new overflow in the same cycle: set wins.
- Input stalls: gaps in valid_i have no effect; the partial word is held indefinitely.

Decomposition:
- Package byte_packer_pkg holds BYTES, CNT_W, the clog2 function, and the FIFO entry layout {bytes, word}.
- One sub-module, word_fifo: a synchronous FWFT FIFO of width MST_DWIDTH+CNT_W and depth FIFO_DEPTH, with push/pop/full/empty/fill and the same clk_sys/rst.
- Packing counter, flush logic and the overflow flag stay in byte_packer.

Test Plan:
1. ready_i=1; bytes DE, AD, BE, EF on 4 consecutive cycles → one cycle after the 4th byte: valid_o=1, data_o=DEADBEEF, bytes_o=4. The word pops the next edge and fill_o returns to 0.
2. Same four bytes with 1–3 idle cycles between each → identical word, valid_o rises only after EF.
3. Bytes 12, 34, then a flush_i pulse → data_o=12340000, bytes_o=2. Then bytes 55, 66, 77, 88 → data_o=55667788, bytes_o=4. Also: flush_i with no pending bytes → no word.
4. ready_i=0, 20 bytes sent 01..14 (hex) → fill_o=4 and the 5th word (11121314) is dropped with overflow_o=1. With ready_i=1 the words drain in order 01020304, 05060708, 090A0B0C, 0D0E0F10, and overflow_o stays 1 until clear_ovf_i.
5. FIFO full with ready_i=1 on the same cycle the 4th byte of a word arrives → no overflow, fill_o stays 4, and the new word appears last in order.
6. One word stored plus 2 bytes pending, then rst pulsed → valid_o, fill_o and data_o go 0 immediately (asynchronous). After release, bytes A1, B2, C3, D4 → data_o=A1B2C3D4 with no stale bytes.
